// File: rtl/contador_pontos_multi.sv
// Score counter for N_JOG independent players: edge-detected hit/miss counting with
// saturation, blocked-line derivation, line-change pulses and a global end-of-game flag.
module contador_pontos_multi #(
    parameter int N_JOG      = 2,
    parameter int W_PONTOS   = 6,
    parameter int MAX_PONTOS = 32,
    parameter int PENALIDADE = 1,
    parameter int PTS_LINHA  = 4,
    parameter int MAX_LINHAS = 7,
    parameter int W_LINHAS   = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         zerar,
    input  logic [N_JOG-1:0]             acertou,
    input  logic [N_JOG-1:0]             errou,
    output logic [N_JOG*W_PONTOS-1:0]    pontos,
    output logic [N_JOG*W_LINHAS-1:0]    linhas_bloq,
    output logic [N_JOG-1:0]             mudou_linha,
    output logic                         fim
);

    localparam logic [W_PONTOS:0] C_MAX  = (W_PONTOS+1)'(MAX_PONTOS);
    localparam logic [W_PONTOS:0] C_PEN  = (W_PONTOS+1)'(PENALIDADE);
    localparam logic [W_PONTOS:0] C_PTS  = (W_PONTOS+1)'(PTS_LINHA);
    localparam logic [W_PONTOS:0] C_MAXL = (W_PONTOS+1)'(MAX_LINHAS);

    logic [N_JOG-1:0]    r_acertouQ;
    logic [N_JOG-1:0]    r_errouQ;
    logic [N_JOG-1:0]    w_evA;
    logic [N_JOG-1:0]    w_evE;
    logic [W_PONTOS-1:0] r_pontos      [N_JOG];
    logic [W_PONTOS-1:0] w_pontosNext  [N_JOG];
    logic [W_LINHAS-1:0] r_linhas      [N_JOG];
    logic [W_LINHAS-1:0] w_linhasNext  [N_JOG];
    logic [N_JOG-1:0]    r_mudou;
    logic                r_fim;
    logic                w_fimNext;
    logic [W_PONTOS:0]   w_atual;
    logic [W_PONTOS:0]   w_prox;
    logic [W_PONTOS:0]   w_quoc;

    // Next-state scores computed one bit wider so neither saturation end can wrap;
    // line count and end flag derive from the next score so they share its edge.
    always_comb begin
        w_evA     = acertou & ~r_acertouQ;
        w_evE     = errou & ~r_errouQ;
        w_fimNext = 1'b0;
        w_atual   = '0;
        w_prox    = '0;
        w_quoc    = '0;
        for (int i = 0; i < N_JOG; i++) begin
            w_atual = {1'b0, r_pontos[i]};
            w_prox  = w_atual;
            if (zerar) begin
                w_prox = '0;
            end else if (enable && w_evA[i] && !w_evE[i]) begin
                w_prox = (w_atual >= C_MAX) ? C_MAX : w_atual + 1'b1;
            end else if (enable && w_evE[i] && !w_evA[i]) begin
                w_prox = (w_atual < C_PEN) ? '0 : w_atual - C_PEN;
            end
            w_pontosNext[i] = w_prox[W_PONTOS-1:0];
            w_quoc          = w_prox / C_PTS;
            w_linhasNext[i] = (w_quoc > C_MAXL) ? C_MAXL[W_LINHAS-1:0] : w_quoc[W_LINHAS-1:0];
            if (w_prox == C_MAX) begin
                w_fimNext = 1'b1;
            end
        end
    end

    // Edge-detect history is captured every cycle, so edges seen while disabled are lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acertouQ <= '0;
            r_errouQ   <= '0;
            r_mudou    <= '0;
            r_fim      <= 1'b0;
            for (int i = 0; i < N_JOG; i++) begin
                r_pontos[i] <= '0;
                r_linhas[i] <= '0;
            end
        end else begin
            r_acertouQ <= acertou;
            r_errouQ   <= errou;
            r_fim      <= w_fimNext;
            for (int i = 0; i < N_JOG; i++) begin
                r_pontos[i] <= w_pontosNext[i];
                r_linhas[i] <= w_linhasNext[i];
                r_mudou[i]  <= (w_linhasNext[i] != r_linhas[i]);
            end
        end
    end

    for (genvar g = 0; g < N_JOG; g++) begin : g_saida
        assign pontos[g*W_PONTOS +: W_PONTOS]      = r_pontos[g];
        assign linhas_bloq[g*W_LINHAS +: W_LINHAS] = r_linhas[g];
    end

    assign mudou_linha = r_mudou;
    assign fim         = r_fim;

endmodule

// File: tb/tb_contador_pontos_multi.sv
// Directed bench for contador_pontos_multi: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them once the DUT has registered the step.
module tb_contador_pontos_multi;

    typedef struct {
        int         due;
        logic [5:0] p0;
        logic [5:0] p1;
        logic [2:0] l0;
        logic [2:0] l1;
        logic [1:0] m;
        logic       f;
    } expect_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        zerar;
    logic [1:0]  acertou;
    logic [1:0]  errou;
    logic [11:0] pontos;
    logic [5:0]  linhas_bloq;
    logic [1:0]  mudou_linha;
    logic        fim;

    expect_t     scoreboard[$];
    int          cycleCount = 0;
    int          total = 0;
    int          bad = 0;

    contador_pontos_multi dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .zerar       (zerar),
        .acertou     (acertou),
        .errou       (errou),
        .pontos      (pontos),
        .linhas_bloq (linhas_bloq),
        .mudou_linha (mudou_linha),
        .fim         (fim)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Comparison helper shared by the monitor.
    task automatic checkOutput(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0d required=%0d", name, cycleCount, actual, required);
        end
    endtask

    // Monitor: pops every expectation whose registered result is now visible.
    always @(negedge clock) begin
        while (scoreboard.size() > 0 && scoreboard[0].due <= cycleCount) begin
            expect_t e;
            e = scoreboard.pop_front();
            if (e.due != cycleCount)
                checkOutput("late_entry", e.due, cycleCount);
            checkOutput("pontos0", int'(pontos[5:0]), int'(e.p0));
            checkOutput("pontos1", int'(pontos[11:6]), int'(e.p1));
            checkOutput("linhas0", int'(linhas_bloq[2:0]), int'(e.l0));
            checkOutput("linhas1", int'(linhas_bloq[5:3]), int'(e.l1));
            checkOutput("mudou_linha", int'(mudou_linha), int'(e.m));
            checkOutput("fim", int'(fim), int'(e.f));
        end
    end

    // Drive one cycle of inputs (called at a negedge) and queue its expected outcome.
    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] e, input logic en,
                                 input logic z, input logic rst,
                                 input int p0, input int p1, input int l0, input int l1,
                                 input logic [1:0] m, input logic f);
        expect_t x;
        acertou = a;
        errou   = e;
        enable  = en;
        zerar   = z;
        reset   = rst;
        x.due = cycleCount + 1;
        x.p0  = 6'(p0);
        x.p1  = 6'(p1);
        x.l0  = 3'(l0);
        x.l1  = 3'(l1);
        x.m   = m;
        x.f   = f;
        scoreboard.push_back(x);
        @(negedge clock);
    endtask

    initial begin
        int p0;
        int p1;
        logic [1:0] m;
        reset = 1'b1; enable = 1'b1; zerar = 1'b0; acertou = '0; errou = '0;
        @(negedge clock);

        // Reset state
        applyStimulus(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0);

        // Four hit pulses on player 0; first blocked line at 4
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(2'b01, 2'b00, 1, 0, 0, k, 0, k / 4, 0, (k == 4) ? 2'b01 : 2'b00, 0);
            applyStimulus(2'b00, 2'b00, 1, 0, 0, k, 0, k / 4, 0, 2'b00, 0);
        end

        // Held level counts once, a fresh rising edge counts again
        applyStimulus(2'b01, 2'b00, 1, 0, 0, 5, 0, 1, 0, 2'b00, 0);
        for (int k = 0; k < 9; k++)
            applyStimulus(2'b01, 2'b00, 1, 0, 0, 5, 0, 1, 0, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 5, 0, 1, 0, 2'b00, 0);
        applyStimulus(2'b01, 2'b00, 1, 0, 0, 6, 0, 1, 0, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 6, 0, 1, 0, 2'b00, 0);

        // Player 1 saturates at 32, lines cap at 7, fim follows the ceiling
        for (int k = 1; k <= 34; k++) begin
            p1 = (k > 32) ? 32 : k;
            m  = ((k % 4) == 0 && k <= 28) ? 2'b10 : 2'b00;
            applyStimulus(2'b10, 2'b00, 1, 0, 0, 6, p1, 1, (p1 / 4 > 7) ? 7 : p1 / 4, m, p1 == 32);
            applyStimulus(2'b00, 2'b00, 1, 0, 0, 6, p1, 1, (p1 / 4 > 7) ? 7 : p1 / 4, 2'b00, p1 == 32);
        end
        applyStimulus(2'b00, 2'b10, 1, 0, 0, 6, 31, 1, 7, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 6, 31, 1, 7, 2'b00, 0);

        // Player 0 drained to 0, then floor holds; simultaneous hit+miss is neutral
        for (int k = 1; k <= 6; k++) begin
            p0 = 6 - k;
            m  = (p0 == 3) ? 2'b01 : 2'b00;
            applyStimulus(2'b00, 2'b01, 1, 0, 0, p0, 31, p0 / 4, 7, m, 0);
            applyStimulus(2'b00, 2'b00, 1, 0, 0, p0, 31, p0 / 4, 7, 2'b00, 0);
        end
        applyStimulus(2'b00, 2'b01, 1, 0, 0, 0, 31, 0, 7, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 0, 31, 0, 7, 2'b00, 0);
        applyStimulus(2'b01, 2'b01, 1, 0, 0, 0, 31, 0, 7, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 0, 31, 0, 7, 2'b00, 0);

        // Disabled edges are dropped, including one still held when enable returns
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b01, 2'b00, 0, 0, 0, 0, 31, 0, 7, 2'b00, 0);
            applyStimulus(2'b00, 2'b00, 0, 0, 0, 0, 31, 0, 7, 2'b00, 0);
        end
        applyStimulus(2'b01, 2'b00, 0, 0, 0, 0, 31, 0, 7, 2'b00, 0);
        applyStimulus(2'b01, 2'b00, 1, 0, 0, 0, 31, 0, 7, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 0, 31, 0, 7, 2'b00, 0);
        applyStimulus(2'b01, 2'b00, 1, 0, 0, 1, 31, 0, 7, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 1, 31, 0, 7, 2'b00, 0);

        // Both players move on the same edges, reaching 9 / 20
        for (int k = 1; k <= 11; k++) begin
            p0 = (k <= 8) ? 1 + k : 9;
            p1 = 31 - k;
            m[0] = (k <= 8) && ((p0 / 4) != ((p0 - 1) / 4));
            m[1] = (p1 / 4) != ((p1 + 1) / 4);
            applyStimulus((k <= 8) ? 2'b01 : 2'b00, 2'b10, 1, 0, 0, p0, p1, p0 / 4, p1 / 4, m, 0);
            applyStimulus(2'b00, 2'b00, 1, 0, 0, p0, p1, p0 / 4, p1 / 4, 2'b00, 0);
        end

        // zerar clears both and overrides simultaneous events
        applyStimulus(2'b11, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b11, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);

        // Reset mid-pulse clears everything, including the edge history
        applyStimulus(2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0);
        applyStimulus(2'b01, 2'b00, 1, 0, 0, 2, 0, 0, 0, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 2, 0, 0, 0, 2'b00, 0);
        applyStimulus(2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 0, 2'b00, 0);
        applyStimulus(2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0);
        applyStimulus(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0);

        repeat (3) @(negedge clock);
        if (scoreboard.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d required=0", scoreboard.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
